nmcu_cmd_issuer: RTL and testbench

NMCU_CMD_ISSUER -- requirements
Module: nmcu_cmd_issuer

---
 rtl/instr_pkg.sv | 26 ++
 rtl/nmcu_pkg.sv | 18 +
 rtl/nmcu_cmd_fifo.sv | 51 +++++
 rtl/nmcu_cmd_issuer.sv | 147 ++++++++++++++
 tb/tb_nmcu_cmd_issuer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - NMCU instruction and response types
package instr_pkg;
    import nmcu_pkg::*;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_MAC   = 4'd3
    } opcode_t;

    typedef struct packed {
        opcode_t               op;
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
        logic [ADDR_WIDTH-1:0] addr_c;
        logic [DATA_WIDTH-1:0] data;
        logic [LEN_WIDTH-1:0]  len;
    } instruction_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            status;
    } nmcu_cpu_resp_t;

endpackage

// File: rtl/nmcu_pkg.sv
// rtl/nmcu_pkg.sv - NMCU widths, issuer FSM states and response status codes
package nmcu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 16;
    localparam int LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_DELIVER
    } issuer_state_t;

    localparam logic [1:0] RESP_OK      = 2'b00;
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

endpackage

// File: rtl/nmcu_cmd_fifo.sv
// rtl/nmcu_cmd_fifo.sv - power-of-two command queue with full/empty flags
module nmcu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/nmcu_cmd_issuer.sv
// rtl/nmcu_cmd_issuer.sv - queues host commands, issues one at a time to the NMCU; NMCU_ISSUER_TIMEOUT_EN adds a response timeout
module nmcu_cmd_issuer
    import nmcu_pkg::*;
    import instr_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_cmd_valid_i,
    input  instruction_t          host_cmd_i,
    output logic                  host_cmd_ready_o,
    output logic                  cpu_instr_valid_o,
    output instruction_t          cpu_instruction_o,
    input  logic                  cpu_instr_ready_i,
    input  logic                  nmcu_resp_valid_i,
    input  nmcu_cpu_resp_t        nmcu_response_i,
    output logic                  nmcu_resp_ready_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic [1:0]            res_status_o,
    output logic                  res_timeout_o,
    output logic                  busy_o,
    output logic [7:0]            err_count_o
);
    localparam int IW = $bits(instruction_t);

    issuer_state_t         state_q, state_d;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [IW-1:0]         fifo_head;
    logic                  take_resp, take_tmo, tmo_hit;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [1:0]            res_status_q;
    logic [7:0]            err_q;

    assign host_cmd_ready_o = !fifo_full;
    assign fifo_push        = host_cmd_valid_i && !fifo_full;

    nmcu_cmd_fifo #(
        .WIDTH (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (host_cmd_i),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d           = state_q;
        cpu_instr_valid_o = 1'b0;
        nmcu_resp_ready_o = 1'b0;
        res_valid_o       = 1'b0;
        fifo_pop          = 1'b0;
        take_resp         = 1'b0;
        take_tmo          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                cpu_instr_valid_o = 1'b1;
                if (cpu_instr_ready_i) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                nmcu_resp_ready_o = 1'b1;
                if (nmcu_resp_valid_i) begin
                    take_resp = 1'b1;
                    state_d   = ST_DELIVER;
                end else if (tmo_hit) begin
                    take_tmo = 1'b1;
                    state_d  = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                res_valid_o = 1'b1;
                if (res_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Result registers only load on DELIVER entry, which keeps them stable while the host stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q   <= '0;
            res_status_q <= '0;
            err_q        <= '0;
        end else begin
            if (take_resp) begin
                res_data_q   <= nmcu_response_i.data;
                res_status_q <= nmcu_response_i.status;
            end else if (take_tmo) begin
                res_data_q   <= '0;
                res_status_q <= RESP_TIMEOUT;
            end
            if (((take_resp && nmcu_response_i.status != RESP_OK) || take_tmo) && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

`ifdef NMCU_ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt_q;
    logic          res_tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            res_tmo_q <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE && cpu_instr_ready_i) tmo_cnt_q <= '0;
            else if (state_q == ST_WAIT_RESP)             tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (take_resp)     res_tmo_q <= 1'b0;
            else if (take_tmo) res_tmo_q <= 1'b1;
        end
    end

    assign tmo_hit       = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign res_timeout_o = res_tmo_q;
`else
    assign tmo_hit       = 1'b0;
    assign res_timeout_o = 1'b0;
`endif

    assign cpu_instruction_o = cpu_instr_valid_o ? instruction_t'(fifo_head) : '0;
    assign res_data_o        = res_data_q;
    assign res_status_o      = res_status_q;
    assign err_count_o       = err_q;
    assign busy_o            = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_nmcu_cmd_issuer.sv
// tb/tb_nmcu_cmd_issuer.sv - directed bench for nmcu_cmd_issuer
module tb_nmcu_cmd_issuer;
    import nmcu_pkg::*;
    import instr_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            host_cmd_valid_i = 1'b0;
    instruction_t    host_cmd_i = '0;
    logic            host_cmd_ready_o;
    logic            cpu_instr_valid_o;
    instruction_t    cpu_instruction_o;
    logic            cpu_instr_ready_i = 1'b0;
    logic            nmcu_resp_valid_i = 1'b0;
    nmcu_cpu_resp_t  nmcu_response_i = '0;
    logic            nmcu_resp_ready_o;
    logic            res_valid_o;
    logic            res_ready_i = 1'b0;
    logic [31:0]     res_data_o;
    logic [1:0]      res_status_o;
    logic            res_timeout_o;
    logic            busy_o;
    logic [7:0]      err_count_o;

    always #5 clk = ~clk;

    nmcu_cmd_issuer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_cmd_valid_i(host_cmd_valid_i), .host_cmd_i(host_cmd_i), .host_cmd_ready_o(host_cmd_ready_o),
        .cpu_instr_valid_o(cpu_instr_valid_o), .cpu_instruction_o(cpu_instruction_o),
        .cpu_instr_ready_i(cpu_instr_ready_i),
        .nmcu_resp_valid_i(nmcu_resp_valid_i), .nmcu_response_i(nmcu_response_i),
        .nmcu_resp_ready_o(nmcu_resp_ready_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_status_o(res_status_o), .res_timeout_o(res_timeout_o),
        .busy_o(busy_o), .err_count_o(err_count_o)
    );

    typedef struct {
        instruction_t cmd;
        int           rdy_dly;
        int           resp_dly;
        logic [31:0]  rdata;
        logic [1:0]   rstat;
        int           exp_err;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_model = 0;
    logic [31:0] mem [int];

    function automatic instruction_t mk(opcode_t op, int a, int b, int c, logic [31:0] d, int len);
        instruction_t t;
        t.op = op; t.addr_a = 16'(a); t.addr_b = 16'(b); t.addr_c = 16'(c);
        t.data = d; t.len = 8'(len);
        return t;
    endfunction

    function automatic logic [31:0] nmcu_model(instruction_t c);
        logic [31:0] va, vb;
        va = mem.exists(int'(c.addr_a)) ? mem[int'(c.addr_a)] : 32'd0;
        vb = mem.exists(int'(c.addr_b)) ? mem[int'(c.addr_b)] : 32'd0;
        case (c.op)
            OP_STORE: begin mem[int'(c.addr_a)] = c.data; return c.data; end
            OP_LOAD:  return va;
            OP_MAC:   begin mem[int'(c.addr_c)] = va * vb; return va * vb; end
            default:  return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input instruction_t c);
        int n = 0;
        host_cmd_i = c;
        host_cmd_valid_i = 1'b1;
        while (!host_cmd_ready_o && n < 200) begin @(negedge clk); n++; end
        chk("push_ready", host_cmd_ready_o, 1'b1);
        @(negedge clk);
        host_cmd_valid_i = 1'b0;
    endtask

    task automatic issue(input instruction_t exp, input int rd, input bit lat);
        int n = 0;
        if (lat) begin
            chk("lat_idle", cpu_instr_valid_o, 1'b0);
            chk("lat_busy", busy_o, 1'b1);
            @(negedge clk);
        end else begin
            while (!cpu_instr_valid_o && n < 100) begin @(negedge clk); n++; end
        end
        chk("issue_valid", cpu_instr_valid_o, 1'b1);
        chk("issue_instr", cpu_instruction_o, exp);
        repeat (rd) begin
            @(negedge clk);
            chk("issue_hold", {cpu_instr_valid_o, nmcu_resp_ready_o}, 2'b10);
            chk("issue_stable", cpu_instruction_o, exp);
        end
        cpu_instr_ready_i = 1'b1;
        @(negedge clk);
        cpu_instr_ready_i = 1'b0;
        chk("wait_entry", {cpu_instr_valid_o, nmcu_resp_ready_o, res_valid_o}, 3'b010);
    endtask

    task automatic respond(input int dly, input logic [31:0] d, input logic [1:0] s);
        repeat (dly) begin
            @(negedge clk);
            chk("wait_hold", {cpu_instr_valid_o, nmcu_resp_ready_o, res_valid_o}, 3'b010);
        end
        nmcu_resp_valid_i = 1'b1;
        nmcu_response_i.data = d;
        nmcu_response_i.status = s;
        @(negedge clk);
        nmcu_resp_valid_i = 1'b0;
        if (s != 2'b00 && err_model < 255) err_model++;
    endtask

    task automatic deliver(input int hold, input logic [31:0] d, input logic [1:0] s, input logic tmo);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            chk("res_valid", res_valid_o, 1'b1);
            chk("res_data", res_data_o, d);
            chk("res_status", res_status_o, s);
            chk("res_timeout", res_timeout_o, tmo);
            chk("err_count", err_count_o, err_model);
            chk("deliver_quiet", {cpu_instr_valid_o, nmcu_resp_ready_o}, 2'b00);
        end
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        chk("res_drop", res_valid_o, 1'b0);
    endtask

    initial begin
        vec_t         vecs[5];
        instruction_t seq[5];
        logic [31:0]  d;
        int           n;

        vecs[0] = '{mk(OP_STORE, 100, 0, 0, 32'd55, 1), 2, 2, 32'd0,        2'b00, 0};
        vecs[1] = '{mk(OP_LOAD, 100, 0, 0, 32'd0, 1),   0, 0, 32'd55,       2'b00, 0};
        vecs[2] = '{mk(OP_MAC, 1, 2, 3, 32'd0, 4),      1, 3, 32'hDEADBEEF, 2'b01, 1};
        vecs[3] = '{mk(OP_NOP, 0, 0, 0, 32'd0, 0),      0, 1, 32'h1234,     2'b10, 2};
        vecs[4] = '{mk(OP_LOAD, 7, 0, 0, 32'd0, 8),     3, 0, 32'hFFFFFFFF, 2'b11, 3};

        repeat (2) @(negedge clk);
        chk("rst_outputs", {host_cmd_ready_o, cpu_instr_valid_o, nmcu_resp_ready_o, res_valid_o,
                            res_timeout_o, busy_o}, 6'b100000);
        chk("rst_data", {res_data_o, res_status_o, err_count_o}, 42'd0);
        chk("rst_instr", cpu_instruction_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            push(vecs[i].cmd);
            issue(vecs[i].cmd, vecs[i].rdy_dly, 1'b1);
            respond(vecs[i].resp_dly, vecs[i].rdata, vecs[i].rstat);
            chk("vec_err", err_count_o, vecs[i].exp_err);
            deliver(0, vecs[i].rdata, vecs[i].rstat, 1'b0);
            chk("vec_idle_busy", busy_o, 1'b0);
        end

        // Host stalls the result for 10 cycles with another command queued.
        seq[0] = mk(OP_STORE, 10, 0, 0, 32'hA5A5, 1);
        seq[1] = mk(OP_LOAD, 10, 0, 0, 32'd0, 1);
        push(seq[0]);
        push(seq[1]);
        issue(seq[0], 0, 1'b0);
        respond(1, 32'hCAFE, 2'b00);
        deliver(10, 32'hCAFE, 2'b00, 1'b0);
        issue(seq[1], 0, 1'b0);
        respond(0, 32'hBEEF, 2'b00);
        deliver(0, 32'hBEEF, 2'b00, 1'b0);

        // Queue full: fifth command waits for the first pop.
        for (int i = 0; i < 5; i++) seq[i] = mk(OP_STORE, 20 + i, 0, 0, 32'(i), 1);
        for (int i = 0; i < 4; i++) push(seq[i]);
        chk("full_ready", host_cmd_ready_o, 1'b0);
        host_cmd_i = seq[4];
        host_cmd_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold", host_cmd_ready_o, 1'b0);
        end
        chk("full_head", cpu_instruction_o, seq[0]);
        cpu_instr_ready_i = 1'b1;
        @(negedge clk);
        cpu_instr_ready_i = 1'b0;
        chk("full_after_pop", host_cmd_ready_o, 1'b1);
        @(negedge clk);
        host_cmd_valid_i = 1'b0;
        chk("full_again", host_cmd_ready_o, 1'b0);
        respond(0, 32'd100, 2'b00);
        deliver(0, 32'd100, 2'b00, 1'b0);
        for (int i = 1; i < 5; i++) begin
            issue(seq[i], 0, 1'b0);
            respond(0, 32'(100 + i), 2'b00);
            deliver(0, 32'(100 + i), 2'b00, 1'b0);
        end
        chk("full_drained", {busy_o, host_cmd_ready_o}, 2'b01);

        // STORE/STORE/MAC/LOAD program issued strictly in order.
        seq[0] = mk(OP_STORE, 100, 0, 0, 32'd55, 1);
        seq[1] = mk(OP_STORE, 101, 0, 0, 32'd2, 1);
        seq[2] = mk(OP_MAC, 100, 101, 200, 32'd0, 1);
        seq[3] = mk(OP_LOAD, 200, 0, 0, 32'd0, 1);
        for (int i = 0; i < 4; i++) push(seq[i]);
        for (int i = 0; i < 4; i++) begin
            issue(seq[i], 0, 1'b0);
            d = nmcu_model(seq[i]);
            respond(1, d, 2'b00);
            if (i == 3) chk("prog_final", res_data_o, 32'd110);
            deliver(2, d, 2'b00, 1'b0);
        end

`ifdef NMCU_ISSUER_TIMEOUT_EN
        seq[0] = mk(OP_LOAD, 300, 0, 0, 32'd0, 1);
        push(seq[0]);
        issue(seq[0], 0, 1'b0);
        n = 0;
        while (!res_valid_o && n < 100) begin @(negedge clk); n++; end
        chk("tmo_cycles", n, 16);
        if (err_model < 255) err_model++;
        deliver(0, 32'd0, 2'b11, 1'b1);
`endif

        // Reset in WAIT_RESP with two commands behind it; late response must be ignored.
        for (int i = 0; i < 3; i++) seq[i] = mk(OP_STORE, 40 + i, 0, 0, 32'(i), 1);
        for (int i = 0; i < 3; i++) push(seq[i]);
        issue(seq[0], 0, 1'b0);
        chk("pre_rst_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {host_cmd_ready_o, cpu_instr_valid_o, nmcu_resp_ready_o, res_valid_o, busy_o},
            5'b10000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        err_model = 0;
        nmcu_resp_valid_i = 1'b1;
        nmcu_response_i.data = 32'h77;
        nmcu_response_i.status = 2'b01;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst", {host_cmd_ready_o, cpu_instr_valid_o, nmcu_resp_ready_o, res_valid_o, busy_o},
                5'b10000);
            chk("post_rst_err", err_count_o, 8'd0);
        end
        nmcu_resp_valid_i = 1'b0;

        // Error counter saturates at 255.
        for (int i = 0; i < 258; i++) begin
            seq[0] = mk(OP_NOP, i, 0, 0, 32'd0, 0);
            push(seq[0]);
            issue(seq[0], 0, 1'b0);
            respond(0, 32'(i), 2'b01);
            deliver(0, 32'(i), 2'b01, 1'b0);
        end
        chk("err_sat", err_count_o, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
